// File: rtl/siso_shift_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// siso_ctrl_pkg
// Shared definitions for the SISO shift controller:
//   state_t   : controller FSM states (IDLE / SHIFT / DONE), 2-bit encoding
//   cnt_width : width of the enabled-cycle counter for a WIDTH/DEPTH pair
// ---------------------------------------------------------------------------
package siso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter must hold values 0..WIDTH+DEPTH-1 inclusive.
  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width + depth + 1);
  endfunction

endpackage

// File: rtl/siso_shift_ctrl_if.sv
// ---------------------------------------------------------------------------
// siso_shift_ctrl_if
// Bundles the controller's producer, consumer and SISO-side signals.
//   in_valid/in_ready/in_data    : parallel word input handshake
//   out_valid/out_ready/out_data : reassembled word output handshake
//   siso_en/siso_din/siso_dout   : serial datapath control and data
//   busy                         : controller is in SHIFT or DONE
// master : the controller side
// slave  : the environment side (producer, consumer and SISO)
// ---------------------------------------------------------------------------
interface siso_shift_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             siso_en;
  logic             siso_din;
  logic             siso_dout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    input  in_valid, in_data, siso_dout, out_ready,
    output in_ready, siso_en, siso_din, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, siso_dout, out_ready,
    input  in_ready, siso_en, siso_din, out_valid, out_data, busy
  );

endinterface

// File: rtl/siso_shift_ctrl.sv
// ---------------------------------------------------------------------------
// siso_shift_ctrl
// Sequencer for an enable-gated DEPTH-stage SISO shift register. A WIDTH-bit
// word accepted in IDLE is shifted LSB-first into the SISO, followed by DEPTH
// zero flush bits. Bits leaving the SISO are reassembled into rx and offered
// on the output handshake in DONE.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : siso_shift_ctrl_if.master (handshakes, SISO control, busy)
// ---------------------------------------------------------------------------
module siso_shift_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  siso_shift_ctrl_if.master  bus
);

  localparam int CW = cnt_width(WIDTH, DEPTH);
  localparam logic [CW-1:0] CNT_FIRST_CAP = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST      = CW'(WIDTH + DEPTH - 1);

  state_t           state;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [CW-1:0]    cnt;
  logic             in_ready_r;
  logic             siso_en_r;
  logic             out_valid_r;
  logic             busy_r;

  // FSM plus tx/rx shifters and the enabled-cycle counter. Handshake and
  // enable flags are registered together with the state so that every output
  // comes straight from a flop. Captures begin only at k=DEPTH: the bit seen
  // at siso_dout then is the first bit of the current word, so whatever the
  // SISO held beforehand never reaches rx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= '0;
      rx          <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      siso_en_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= SHIFT;
            tx         <= bus.in_data;
            rx         <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            siso_en_r  <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        SHIFT: begin
          tx <= tx >> 1;
          if (cnt >= CNT_FIRST_CAP) begin
            rx <= (rx >> 1) | (WIDTH'(bus.siso_dout) << (WIDTH - 1));
          end
          if (cnt == CNT_LAST) begin
            state       <= DONE;
            siso_en_r   <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          siso_en_r   <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // tx has drained to zero by the time SHIFT ends, but gating with the enable
  // keeps siso_din quiet outside SHIFT regardless of tx contents.
  assign bus.siso_din  = siso_en_r & tx[0];
  assign bus.siso_en   = siso_en_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = rx;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_siso_shift_ctrl
// Pairs three controller instances (8/4, 1/1, 5/7) with enable-gated SISO
// models and checks loopback results against a scoreboard of accepted words.
// ---------------------------------------------------------------------------
module tb_siso_shift_ctrl;
  import siso_ctrl_pkg::*;

  localparam int WA = 8, DA = 4;
  localparam int WB = 1, DB = 1;
  localparam int WC = 5, DC = 7;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [WA-1:0] sbq_a[$];
  logic [WB-1:0] sbq_b[$];
  logic [WC-1:0] sbq_c[$];

  always #5 clk = ~clk;

  // Free-running edge counter used to measure accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  siso_shift_ctrl_if #(.WIDTH(WA)) bus_a ();
  siso_shift_ctrl_if #(.WIDTH(WB)) bus_b ();
  siso_shift_ctrl_if #(.WIDTH(WC)) bus_c ();

  siso_shift_ctrl #(.WIDTH(WA), .DEPTH(DA)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  siso_shift_ctrl #(.WIDTH(WB), .DEPTH(DB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  siso_shift_ctrl #(.WIDTH(WC), .DEPTH(DC)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  // SISO models: not reset, and preloaded with ones so stale contents are
  // visible if they ever leak into a result.
  logic [DA-1:0] siso_a = '1;
  logic          siso_b = 1'b1;
  logic [DC-1:0] siso_c = '1;

  always @(posedge clk) if (bus_a.siso_en) siso_a <= {siso_a[DA-2:0], bus_a.siso_din};
  always @(posedge clk) if (bus_b.siso_en) siso_b <= bus_b.siso_din;
  always @(posedge clk) if (bus_c.siso_en) siso_c <= {siso_c[DC-2:0], bus_c.siso_din};

  assign bus_a.siso_dout = siso_a[DA-1];
  assign bus_b.siso_dout = siso_b;
  assign bus_c.siso_dout = siso_c[DC-1];

  // Drive a word into instance A once it is ready; returns at the negedge
  // following the accepting edge (SHIFT cycle k=0).
  task automatic send_a(input logic [WA-1:0] w);
    int n = 0;
    while (bus_a.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = w;
    @(posedge clk);
    sbq_a.push_back(w);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_valid_a(output int edges);
    edges = 0;
    while (bus_a.out_valid !== 1'b1 && edges < 200) begin @(negedge clk); edges++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h5A; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;    bus_b.out_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0;    bus_c.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus_a.in_ready !== 1'b1 || bus_a.siso_en !== 1'b0 || bus_a.out_valid !== 1'b0 ||
          bus_a.out_data !== 8'h00 || bus_a.busy !== 1'b0 || bus_a.siso_din !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold cycle %0d: ready=%b en=%b din=%b valid=%b data=%h busy=%b, required 1 0 0 0 00 0",
                 i, bus_a.in_ready, bus_a.siso_en, bus_a.siso_din, bus_a.out_valid, bus_a.out_data, bus_a.busy);
      end
    end
    bus_a.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus_a.busy !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_accept: busy=%b ready=%b, required 0 1", bus_a.busy, bus_a.in_ready);
    end
  endtask

  task automatic test_loopback();
    logic [11:0]   din_exp = 12'b0000_1010_0101;
    logic [WA-1:0] exp;
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'hA5;
    @(posedge clk);
    sbq_a.push_back(8'hA5);
    for (int k = 0; k < WA + DA; k++) begin
      @(negedge clk);
      if (k == 0) bus_a.in_valid = 1'b0;
      tests_run++;
      if (bus_a.siso_en !== 1'b1 || bus_a.siso_din !== din_exp[k] || bus_a.out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL loopback_din k=%0d: en=%b din=%b valid=%b, required en=1 din=%b valid=0",
                 k, bus_a.siso_en, bus_a.siso_din, bus_a.out_valid, din_exp[k]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus_a.out_valid !== 1'b1 || bus_a.siso_en !== 1'b0 || bus_a.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL loopback_valid_time: valid=%b en=%b busy=%b at edge %0d after accept, required 1 0 1",
               bus_a.out_valid, bus_a.siso_en, bus_a.busy, WA + DA);
    end
    tests_run++;
    if (sbq_a.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL loopback_data: output with empty scoreboard");
    end else begin
      exp = sbq_a.pop_front();
      if (bus_a.out_data !== exp) begin
        tests_failed++;
        $display("[TB] FAIL loopback_data: got %h, required %h", bus_a.out_data, exp);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL loopback_idle: ready=%b valid=%b busy=%b, required 1 0 0",
               bus_a.in_ready, bus_a.out_valid, bus_a.busy);
    end
  endtask

  task automatic test_backpressure();
    int            edges;
    logic [WA-1:0] exp;
    bus_a.out_ready = 1'b0;
    send_a(8'h3C);
    wait_valid_a(edges);
    tests_run++;
    if (edges != WA + DA) begin
      tests_failed++;
      $display("[TB] FAIL bp_latency: got %0d edges, required %0d", edges, WA + DA);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h3C || bus_a.in_ready !== 1'b0 || bus_a.siso_en !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold cycle %0d: valid=%b data=%h ready=%b en=%b, required 1 3c 0 0",
                 i, bus_a.out_valid, bus_a.out_data, bus_a.in_ready, bus_a.siso_en);
      end
      bus_a.in_valid = (i % 2 == 0);
      bus_a.in_data  = 8'h77;
      @(negedge clk);
    end
    tests_run++;
    if (sbq_a.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_data: output with empty scoreboard");
    end else begin
      exp = sbq_a.pop_front();
      if (bus_a.out_data !== exp) begin
        tests_failed++;
        $display("[TB] FAIL bp_data: got %h, required %h", bus_a.out_data, exp);
      end
    end
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'h77;
    @(negedge clk);
    tests_run++;
    if (bus_a.in_ready !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_release_idle: ready=%b busy=%b valid=%b, required 1 0 0",
               bus_a.in_ready, bus_a.busy, bus_a.out_valid);
    end
    @(posedge clk);
    sbq_a.push_back(8'h77);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    tests_run++;
    if (bus_a.busy !== 1'b1 || bus_a.siso_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_second_accept: busy=%b en=%b, required 1 1", bus_a.busy, bus_a.siso_en);
    end
    wait_valid_a(edges);
    tests_run++;
    if (sbq_a.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_second_data: output with empty scoreboard");
    end else begin
      exp = sbq_a.pop_front();
      if (bus_a.out_data !== exp || edges != WA + DA) begin
        tests_failed++;
        $display("[TB] FAIL bp_second_data: got %h after %0d edges, required %h after %0d", bus_a.out_data, edges, exp, WA + DA);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int            edges;
    logic [WA-1:0] exp;
    bus_a.out_ready = 1'b1;
    send_a(8'hF0);
    for (int k = 0; k < 6; k++) @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus_a.in_ready !== 1'b1 || bus_a.siso_en !== 1'b0 || bus_a.siso_din !== 1'b0 ||
        bus_a.out_valid !== 1'b0 || bus_a.out_data !== 8'h00 || bus_a.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_shift: ready=%b en=%b din=%b valid=%b data=%h busy=%b, required 1 0 0 0 00 0",
               bus_a.in_ready, bus_a.siso_en, bus_a.siso_din, bus_a.out_valid, bus_a.out_data, bus_a.busy);
    end
    sbq_a.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_a(8'h81);
    wait_valid_a(edges);
    tests_run++;
    if (sbq_a.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL dirty_siso_data: output with empty scoreboard");
    end else begin
      exp = sbq_a.pop_front();
      if (bus_a.out_data !== exp || edges != WA + DA) begin
        tests_failed++;
        $display("[TB] FAIL dirty_siso_data: got %h after %0d edges, required %h after %0d", bus_a.out_data, edges, exp, WA + DA);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int            t1, t2, n, edges;
    bit            seen_first;
    logic [WA-1:0] exp;
    bus_a.out_ready = 1'b1;
    n = 0;
    while (bus_a.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hFF;
    @(posedge clk);
    sbq_a.push_back(8'hFF);
    @(negedge clk);
    t1 = cyc;
    bus_a.in_data = 8'h00;
    n = 0;
    seen_first = 1'b0;
    while (bus_a.in_ready !== 1'b1 && n < 100) begin
      if (bus_a.out_valid === 1'b1) begin
        seen_first = 1'b1;
        tests_run++;
        if (sbq_a.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_first_data: output with empty scoreboard");
        end else begin
          exp = sbq_a.pop_front();
          if (bus_a.out_data !== exp) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_data: got %h, required %h", bus_a.out_data, exp);
          end
        end
      end
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (seen_first !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first_seen: got %b, required 1", seen_first);
    end
    @(posedge clk);
    sbq_a.push_back(8'h00);
    @(negedge clk);
    t2 = cyc;
    bus_a.in_valid = 1'b0;
    tests_run++;
    if (t2 - t1 != WA + DA + 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_spacing: got %0d cycles, required %0d", t2 - t1, WA + DA + 2);
    end
    wait_valid_a(edges);
    tests_run++;
    if (sbq_a.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second_data: output with empty scoreboard");
    end else begin
      exp = sbq_a.pop_front();
      if (bus_a.out_data !== exp || edges != WA + DA) begin
        tests_failed++;
        $display("[TB] FAIL b2b_second_data: got %h after %0d edges, required %h after %0d", bus_a.out_data, edges, exp, WA + DA);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sweep_w1d1();
    int            n, edges;
    logic [WB-1:0] w, exp;
    for (int i = 0; i < 4; i++) begin
      w = (i < 2) ? WB'(i) : WB'($urandom_range(0, 1));
      n = 0;
      while (bus_b.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = w;
      @(posedge clk);
      sbq_b.push_back(w);
      @(negedge clk);
      bus_b.in_valid = 1'b0;
      edges = 0;
      while (bus_b.out_valid !== 1'b1 && edges < 200) begin @(negedge clk); edges++; end
      tests_run++;
      if (sbq_b.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL sweep_w1d1[%0d]: output with empty scoreboard", i);
      end else begin
        exp = sbq_b.pop_front();
        if (bus_b.out_data !== exp || edges != WB + DB) begin
          tests_failed++;
          $display("[TB] FAIL sweep_w1d1[%0d]: got %h after %0d edges, required %h after %0d", i, bus_b.out_data, edges, exp, WB + DB);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sweep_w5d7();
    int            n, edges;
    logic [WC-1:0] w, exp;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 5'h1F : WC'($urandom_range(0, 31));
      n = 0;
      while (bus_c.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      bus_c.in_valid = 1'b1;
      bus_c.in_data  = w;
      @(posedge clk);
      sbq_c.push_back(w);
      @(negedge clk);
      bus_c.in_valid = 1'b0;
      edges = 0;
      while (bus_c.out_valid !== 1'b1 && edges < 200) begin @(negedge clk); edges++; end
      tests_run++;
      if (sbq_c.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL sweep_w5d7[%0d]: output with empty scoreboard", i);
      end else begin
        exp = sbq_c.pop_front();
        if (bus_c.out_data !== exp || edges != WC + DC) begin
          tests_failed++;
          $display("[TB] FAIL sweep_w5d7[%0d]: got %h after %0d edges, required %h after %0d", i, bus_c.out_data, edges, exp, WC + DC);
        end
      end
      @(negedge clk);
    end
  endtask

  // Scenario sequence; each task leaves the bench at a negedge.
  initial begin
    test_reset();
    test_loopback();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_sweep_w1d1();
    test_sweep_w5d7();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound in case a scenario stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/siso_shift_ctrl.md
# siso_shift_ctrl

Sequencer for an enable-gated serial-in/serial-out shift register of DEPTH stages. It accepts a WIDTH-bit word over a valid/ready handshake and drives the word LSB-first into the SISO serial input. It then flushes the SISO with zeros, reassembles the bits emerging at the SISO output into a word, and presents that word on a valid/ready output port. It sits between a parallel producer/consumer and the SISO datapath, which it owns exclusively.

## Interface
- WIDTH, 8, bits per word (≥1)
- DEPTH, 4, SISO stage count, i.e. serial latency in enabled cycles (≥1)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  producer word valid
- in_ready  output  1  controller can accept a word
- in_data  input  WIDTH  word to shift
- siso_en  output  1  SISO shift enable; SISO shifts on the rising clk edge when high
- siso_din  output  1  serial bit into SISO stage 0
- siso_dout  input  1  SISO last-stage output
- out_valid  output  1  reassembled word valid
- out_ready  input  1  consumer accepts word
- out_data  output  WIDTH  reassembled word
- busy  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- IDLE:
  - in_ready=1, siso_en=0, siso_din=0.
  - If in_valid is high at a clk edge, latch in_data into tx register, clear cnt and rx, and go to SHIFT.
- SHIFT:
  - siso_en=1 every cycle.
  - siso_din=tx[0]; tx shifts right by one (zero-fill) on each edge.
  - cnt counts enabled cycles k=0..WIDTH+DEPTH-1.
  - For k<WIDTH, siso_din carries in_data bit k. For k≥WIDTH, siso_din=0 (flush).
  - At the edge ending cycle k with k≥DEPTH, capture siso_dout into rx: rx = {siso_dout, rx[WIDTH-1:1]}. After WIDTH captures, rx[i] = bit i of the shifted word.
  - At the edge ending k=WIDTH+DEPTH-1, go to DONE.
- DONE:
  - out_valid=1; out_data=rx, held stable.
  - siso_en=0, in_ready=0.
  - On out_ready high at an edge, go to IDLE.
- out_data is driven from rx in all states. It is 0 after reset and is updated only by captures.
- in_valid is ignored outside IDLE. No word is queued.
- cnt width: $clog2(WIDTH+DEPTH+1).

## Timing
- Reset values: state=IDLE, in_ready=1, siso_en=0, siso_din=0, out_valid=0, out_data=0, busy=0, tx=0, rx=0, cnt=0.
- Reset asserted mid-SHIFT or mid-DONE: all registers take their reset values immediately; the in-flight word is dropped.
- Stale SISO contents never corrupt a result: capture starts at k=DEPTH, so every captured bit originates from the current word.
- Accept at edge t0. SHIFT occupies cycles t0+1..t0+WIDTH+DEPTH. out_valid rises in cycle t0+WIDTH+DEPTH+1. With the defaults this is 12 SHIFT cycles and out_valid 13 cycles after accept.
- out_ready already high when DONE is entered: one DONE cycle, IDLE on the next cycle.
- Minimum accept-to-accept spacing: WIDTH+DEPTH+2 cycles.
- All outputs are decoded from registered state and registers; there are no combinational input-to-output paths.

## Structure
- Package siso_ctrl_pkg holds:
  - the state enum (IDLE/SHIFT/DONE, 2-bit encoding);
  - a cnt-width function of WIDTH and DEPTH.
- Single module, no sub-modules; the FSM, tx/rx shifters and cnt are all local.
- The bench pairs the controller with a DEPTH-stage enable-gated SISO model, where siso_dout is the last stage.

## Test plan
- Reset: hold reset for 3 cycles with in_valid=1 → in_ready=1, siso_en=0, out_valid=0, out_data=0, busy=0 throughout; no accept while reset is high.
- Loopback 0xA5: siso_din over the 12 SHIFT cycles = 1,0,1,0,0,1,0,1,0,0,0,0; out_valid 13 cycles after accept with out_data=0xA5.
- Backpressure: send 0x3C, hold out_ready=0 for 5 cycles of DONE while pulsing in_valid with 0x77 → out_data stays 0x3C, in_ready=0, siso_en=0; after out_ready=1, IDLE, then 0x77 is accepted.
- Reset mid-shift: send 0xF0, assert reset during SHIFT cycle k=6 → outputs take reset values at once; then send 0x81 into the dirty SISO → out_data=0x81.
- Back-to-back: in_valid held with 0xFF then 0x00, out_ready=1 → results 0xFF then 0x00, second accept exactly 14 cycles after the first.
- Parameter sweep: WIDTH=1/DEPTH=1 and WIDTH=5/DEPTH=7 with random words → out_data equals in_data; out_valid at accept+WIDTH+DEPTH+1.
